vc_pop_ctrl: RTL
================

VC_POP_CTRL -- requirements
Module: vc_pop_ctrl

Interface
REQ-001 The block SHALL have parameter MAXC, default 16, giving the maximum credits per virtual channel.
REQ-002 The block SHALL have parameter CW, default 5, giving the credit counter width; CW SHALL be at least clog2(MAXC+1).
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 init  in  1  while high, the block SHALL hold in INIT and load credit limits.
REQ-006 cred_init0, cred_init1  in  CW each  credit limit for VC0/VC1; sampled only in INIT.
REQ-007 main_empty  in  1  main FIFO is empty; the FIFO is first-word-fall-through.
REQ-008 main_head  in  6  main FIFO head word; bit 5 is vc_id.
REQ-009 vc_ret0, vc_ret1  in  1 each  one credit returned; pulse means one word left VC0/VC1 FIFO.
REQ-010 main_pop  out  1  pop strobe to main FIFO; also drives the demux valid_in.
REQ-011 pop_vc  out  1  vc_id of the word popped this cycle; 0 when main_pop=0.
REQ-012 credit0, credit1  out  CW each  current available credits.
REQ-013 state_out  out  3  current FSM state encoding.
REQ-014 idle_out  out  1  the datapath is drained and quiescent.
REQ-015 error_out  out  1  sticky credit-overflow error.

Function
REQ-016 States SHALL be encoded RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4; state_out SHALL equal the current state register.
REQ-017 RESET SHALL go to INIT unconditionally on the next cycle.
REQ-018 INIT: each cycle, lim0/lim1 and credit0/credit1 SHALL load min(cred_initX, MAXC); INIT SHALL exit to IDLE on the first cycle with init=0.
REQ-019 IDLE: init=1 SHALL go to INIT; otherwise main_empty=0 SHALL go to ACTIVE; otherwise the FSM SHALL stay in IDLE.
REQ-020 ACTIVE: init=1 SHALL go to INIT with main_pop forced to 0 that cycle; otherwise main_empty=1 SHALL go to IDLE.
REQ-021 main_pop SHALL be combinational and equal: state==ACTIVE, init=0, main_empty=0, and credit[main_head[5]] > 0.
REQ-022 When the head VC has 0 credits, main_pop SHALL stay 0 (head-of-line block) and the FSM SHALL stay in ACTIVE.
REQ-023 Credit update per VC each cycle, outside INIT/RESET: credit += ret − pop_to_vc.
REQ-024 A simultaneous pop and return on the same VC SHALL leave that credit unchanged.
REQ-025 A return with credit==limX and no same-cycle pop to that VC SHALL be an overflow: the FSM SHALL go to ERROR and the credit SHALL not change.
REQ-026 ERROR SHALL be exited only by reset: error_out=1, main_pop=0, init ignored, credits frozen.
REQ-027 Credit returns in IDLE SHALL be counted; returns arriving while in INIT SHALL be discarded.
REQ-028 idle_out SHALL be 1 iff state==IDLE, credit0==lim0 and credit1==lim1.
REQ-029 Pop-to-pop latency SHALL be 0 cycles: one word per cycle back-to-back while the pop condition holds.
REQ-030 The IDLE→ACTIVE transition SHALL cost one cycle, so the first pop occurs one cycle after main_empty falls.

Reset
REQ-031 On reset=1 at a rising edge, the FSM SHALL enter RESET and clear lim0, lim1, credit0, credit1 and the error flag to 0.
REQ-032 While state==RESET: main_pop=0, pop_vc=0, error_out=0, idle_out=0, state_out=0.
REQ-033 Reset SHALL have priority over every other event, including in ERROR and mid-pop; a pop asserted in the same cycle SHALL not be counted.

Verification
REQ-034 Bench SHALL cover init sequence: reset 2 cycles, init=1 with cred_init0=4, cred_init1=20 → credit0=4, credit1=16, state RESET→INIT→IDLE, idle_out=1.
REQ-035 Bench SHALL cover credit exhaustion: limits 2/2, five VC0 heads, no returns → exactly 2 consecutive main_pop with pop_vc=0, then main_pop=0; credit0=0, state ACTIVE.
REQ-036 Bench SHALL cover simultaneous events: credit0=1, VC0 head, vc_ret0=1 in the pop cycle → pop occurs, credit0 stays 1; the next head pops the following cycle.
REQ-037 Bench SHALL cover overflow: IDLE with credit1=lim1=3, vc_ret1 pulse → ERROR next cycle, error_out=1, main_pop=0 despite main_empty=0, init=1 ignored.
REQ-038 Bench SHALL cover mixed traffic: limits 8/8, heads alternating vc_id 0/1 ×6 → 6 back-to-back pops, pop_vc alternating, credit0=credit1=5, then IDLE when empty.
REQ-039 Bench SHALL cover mid-operation reset: reset during an ACTIVE pop → next cycle state_out=0, credits 0, and the popped word is not counted.

Source files
------------

// File: rtl/vc_pop_ctrl.sv
// vc_pop_ctrl: credit-gated pop controller steering a FWFT main FIFO into two virtual channels.
module vc_pop_ctrl #(
  parameter int MAXC = 16,
  parameter int CW   = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic [CW-1:0] cred_init0,
  input  logic [CW-1:0] cred_init1,
  input  logic          main_empty,
  input  logic [5:0]    main_head,
  input  logic          vc_ret0,
  input  logic          vc_ret1,
  output logic          main_pop,
  output logic          pop_vc,
  output logic [CW-1:0] credit0,
  output logic [CW-1:0] credit1,
  output logic [2:0]    state_out,
  output logic          idle_out,
  output logic          error_out
);
  typedef enum logic [2:0] {
    RESET  = 3'd0,
    INIT   = 3'd1,
    IDLE   = 3'd2,
    ACTIVE = 3'd3,
    ERROR  = 3'd4
  } state_t;
  localparam logic [CW-1:0] MAX = CW'(MAXC);
  state_t state, state_nx;
  logic [CW-1:0] lim0, lim1, clamp0, clamp1, credit0_nx, credit1_nx;
  logic err, run, pop0, pop1, ovf0, ovf1;
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RESET;
      lim0    <= '0;
      lim1    <= '0;
      credit0 <= '0;
      credit1 <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      lim0    <= state == INIT ? clamp0 : lim0;
      lim1    <= state == INIT ? clamp1 : lim1;
      credit0 <= credit0_nx;
      credit1 <= credit1_nx;
      err     <= err | (state_nx == ERROR);
    end
  end
  // overflow is checked before init so a bad return is never masked by a re-init
  always_comb begin
    state_nx = state;
    case (state)
      RESET:   state_nx = INIT;
      INIT:    state_nx = init ? INIT : IDLE;
      IDLE:    state_nx = (ovf0 | ovf1) ? ERROR : init ? INIT : !main_empty ? ACTIVE : IDLE;
      ACTIVE:  state_nx = (ovf0 | ovf1) ? ERROR : init ? INIT : main_empty ? IDLE : ACTIVE;
      ERROR:   state_nx = ERROR;
      default: state_nx = RESET;
    endcase
  end
  always_comb begin
    clamp0     = cred_init0 > MAX ? MAX : cred_init0;
    clamp1     = cred_init1 > MAX ? MAX : cred_init1;
    run        = state == IDLE || state == ACTIVE;
    main_pop   = state == ACTIVE && !init && !main_empty && (main_head[5] ? |credit1 : |credit0);
    pop_vc     = main_pop & main_head[5];
    pop0       = main_pop & ~main_head[5];
    pop1       = main_pop & main_head[5];
    ovf0       = run && vc_ret0 && !pop0 && credit0 == lim0;
    ovf1       = run && vc_ret1 && !pop1 && credit1 == lim1;
    credit0_nx = state == INIT ? clamp0 : (run && !ovf0) ? credit0 + CW'(vc_ret0) - CW'(pop0) : credit0;
    credit1_nx = state == INIT ? clamp1 : (run && !ovf1) ? credit1 + CW'(vc_ret1) - CW'(pop1) : credit1;
    state_out  = state;
    idle_out   = state == IDLE && credit0 == lim0 && credit1 == lim1;
    error_out  = err;
  end
endmodule
